btn_event: RTL

- Parametrised N-channel event generator; successor to the single-bit one-cycle rising-edge pulse block.
- Per channel: synchronises a raw asynchronous input, debounces it, and emits one-cycle event pulses.
- Pulse polarity is runtime-selectable: rise, fall, both or off.
- Optional auto-repeat while held.
- Sits between board buttons/switches and game control logic (direction, pause, start).

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_event_chan.sv | 124 ++++++++++++
 rtl/btn_event.sv | 38 +++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the btn_event block: edge-mode encodings and
// the counter width helper used to size the debounce and repeat counters.
package btn_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    // Bits needed for a counter that must hold values 0..max_count.
    function automatic int cnt_width(input int max_count);
        if (max_count < 1) begin
            return 1;
        end else begin
            return $clog2(max_count + 1);
        end
    endfunction

endpackage

// File: rtl/btn_event_chan.sv
// One input channel: synchroniser, debouncer, mode-gated edge pulse and
// auto-repeat generator. All outputs come straight from flops.
module btn_event_chan
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic [1:0] mode,
    output logic       level,
    output logic       pulse,
    output logic       rpt
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW   = cnt_width(DEB_CYCLES);
    localparam int RW   = cnt_width(RMAX);
    localparam bit RPT_EN = (REPEAT_DELAY > 0);

    // Terminal counts: the edge on which the counter holds this value is
    // the edge that accepts the new level / emits the repeat.
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
    logic [RW-1:0]          rpt_cnt_q, rpt_cnt_d;
    logic                   rpt_ph_q, rpt_ph_d;   // 0: initial delay, 1: periodic phase
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   rpt_q, rpt_d;
    logic                   s_s;
    logic                   flip_s;

    assign s_s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift and debounce: count consecutive disagreeing cycles.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], din};
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        flip_s    = 1'b0;
        if (s_s == level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            flip_s    = 1'b1;
            level_d   = ~level_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
        end
    end

    // Edge pulse on an accepted flip, filtered by the current mode.
    always_comb begin
        pulse_d = 1'b0;
        case (mode)
            MODE_RISE: pulse_d = flip_s & ~level_q;
            MODE_FALL: pulse_d = flip_s &  level_q;
            MODE_BOTH: pulse_d = flip_s;
            MODE_OFF:  pulse_d = 1'b0;
            default:   pulse_d = 1'b0;
        endcase
    end

    // Auto-repeat: delay phase after the press, then fixed period while held.
    always_comb begin
        rpt_d     = 1'b0;
        rpt_cnt_d = rpt_cnt_q;
        rpt_ph_d  = rpt_ph_q;
        if (!RPT_EN) begin
            rpt_cnt_d = '0;
            rpt_ph_d  = 1'b0;
        end else if (flip_s) begin
            // Either flip direction restarts from the delay phase; a falling
            // flip also guarantees no repeat on the release edge.
            rpt_cnt_d = '0;
            rpt_ph_d  = 1'b0;
        end else if (level_q) begin
            if (rpt_cnt_q == (rpt_ph_q ? PER_LAST : DLY_LAST)) begin
                rpt_d     = (mode != MODE_OFF);
                rpt_cnt_d = '0;
                rpt_ph_d  = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RW'(1);
            end
        end else begin
            rpt_cnt_d = '0;
            rpt_ph_d  = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            deb_cnt_q <= '0;
            rpt_cnt_q <= '0;
            rpt_ph_q  <= 1'b0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            deb_cnt_q <= deb_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            rpt_ph_q  <= rpt_ph_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            rpt_q     <= rpt_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;
    assign rpt   = rpt_q;

endmodule

// File: rtl/btn_event.sv
// N-channel button/switch event generator. Each channel is independent;
// the top level only fans the global edge mode out to every channel.
module btn_event
    import btn_pkg::*;
#(
    parameter int N             = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic [1:0]   mode,
    output logic [N-1:0] level,
    output logic [N-1:0] pulse,
    output logic [N-1:0] rpt
);

    for (genvar i = 0; i < N; i++) begin : g_chan
        btn_event_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEB_CYCLES    (DEB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (din[i]),
            .mode  (mode),
            .level (level[i]),
            .pulse (pulse[i]),
            .rpt   (rpt[i])
        );
    end

endmodule
